// File: rtl/hash_digest_reader.sv
// Digest read-out: snapshots a NUM_WORDS x WORD_W digest on start and streams it
// word a first over a valid/ready handshake, with index, last and done indications.
//
// state | meaning
// IDLE  | waiting for start; out_valid low
// SEND  | presenting snapshot words until the final word is accepted
module hash_digest_reader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WORD_W*NUM_WORDS-1:0] digest_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_word,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int DIG_W = WORD_W * NUM_WORDS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [DIG_W-1:0]    snap_q, snap_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer;
  logic                at_last;

  assign xfer    = valid_q & out_ready;
  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (xfer && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The snapshot holds only the words not yet presented; it shifts up one word
  // per transfer so the next word is always at the top.
  always_comb begin
    snap_d  = snap_q;
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = digest_in << WORD_W;
          word_d  = digest_in[DIG_W-1 -: WORD_W];
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = logic'(NUM_WORDS == 1);
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (xfer) begin
          if (at_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            word_d  = snap_q[DIG_W-1 -: WORD_W];
            snap_d  = snap_q << WORD_W;
            last_d  = ((idx_q + IDX_W'(1)) == LAST_IDX);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
